// File: rtl/ram_sig_pkg.sv
// ram_sig_pkg: shared defaults and address-width helper for the single-port RAM and its FIFO user.
package ram_sig_pkg;
    localparam int RAM_SIG_WIDTH = 8;
    localparam int RAM_SIG_DEPTH = 128;
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/ram_sig_1p.sv
// ram_sig_1p: single-port synchronous RAM, write or read each cycle, registered read data.
module ram_sig_1p
    import ram_sig_pkg::*;
#(
    parameter int WIDTH = RAM_SIG_WIDTH,
    parameter int DEPTH = RAM_SIG_DEPTH,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] data_out
);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_data_out;
    logic             w_in_range;
    assign w_in_range = {1'b0, addr} < DEPTH_L;
    // Array kept in its own reset-free block so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wren && !rst && w_in_range) r_mem[addr] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (rst) r_data_out <= '0;
        else if (!wren) r_data_out <= w_in_range ? r_mem[addr] : '0;
    end
    assign data_out = r_data_out;
endmodule

// File: tb/tb_ram_sig_1p.sv
// tb_ram_sig_1p: directed and randomized checks of ram_sig_1p against an array reference model.
module tb_ram_sig_1p;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wren = 1'b0;
    logic [7:0]  din = '0;
    logic [6:0]  addr = '0;
    logic [7:0]  dout;
    logic        wren5 = 1'b0;
    logic [15:0] din5 = '0;
    logic [2:0]  addr5 = '0;
    logic [15:0] dout5;
    int checks = 0;
    int errors = 0;
    logic [7:0] mem_m [128];
    logic [7:0] exp_q;

    always #5 clk = ~clk;

    ram_sig_1p #(.WIDTH(8), .DEPTH(128)) dut (
        .clk(clk), .rst(rst), .wren(wren), .data_in(din), .addr(addr), .data_out(dout)
    );
    ram_sig_1p #(.WIDTH(16), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .wren(wren5), .data_in(din5), .addr(addr5), .data_out(dout5)
    );

    // One clock on the 128-deep port; the model tracks what data_out must hold afterwards.
    task automatic cyc(input logic r, input logic w, input logic [6:0] a, input logic [7:0] d);
        rst = r; wren = w; addr = a; din = d;
        @(posedge clk); #1;
        if (r) exp_q = 8'h00;
        else if (w) mem_m[a] = d;
        else exp_q = mem_m[a];
    endtask

    task automatic cyc5(input logic w, input logic [2:0] a, input logic [15:0] d);
        rst = 1'b0; wren = 1'b0; wren5 = w; addr5 = a; din5 = d;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        cyc(1'b0, 1'b1, 7'd3, 8'hA5);
        cyc(1'b0, 1'b0, 7'd3, 8'h00);
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL pre_reset got %h want a5", dout); end
        cyc(1'b1, 1'b1, 7'd3, 8'h5A);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_edge1 got %h want 00", dout); end
        cyc(1'b1, 1'b0, 7'd3, 8'h00);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_edge2 got %h want 00", dout); end
        cyc(1'b0, 1'b0, 7'd3, 8'h00);
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL reset_write_discarded got %h want a5", dout); end
    endtask

    task automatic test_write_read;
        cyc(1'b0, 1'b1, 7'd0, 8'h11);
        cyc(1'b0, 1'b1, 7'd1, 8'h22);
        cyc(1'b0, 1'b1, 7'd127, 8'h33);
        cyc(1'b0, 1'b0, 7'd0, 8'h00);
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL read0 got %h want 11", dout); end
        cyc(1'b0, 1'b0, 7'd1, 8'h00);
        checks++; if (dout !== 8'h22) begin errors++; $display("FAIL read1 got %h want 22", dout); end
        cyc(1'b0, 1'b0, 7'd127, 8'h00);
        checks++; if (dout !== 8'h33) begin errors++; $display("FAIL read127 got %h want 33", dout); end
    endtask

    task automatic test_hold_on_write;
        cyc(1'b0, 1'b0, 7'd1, 8'h00);
        checks++; if (dout !== 8'h22) begin errors++; $display("FAIL hold_pre got %h want 22", dout); end
        cyc(1'b0, 1'b1, 7'd5, 8'h44);
        checks++; if (dout !== 8'h22) begin errors++; $display("FAIL hold_during_write got %h want 22", dout); end
        cyc(1'b0, 1'b0, 7'd5, 8'h00);
        checks++; if (dout !== 8'h44) begin errors++; $display("FAIL read5 got %h want 44", dout); end
    endtask

    task automatic test_overwrite;
        cyc(1'b0, 1'b1, 7'd1, 8'h55);
        cyc(1'b0, 1'b0, 7'd1, 8'h00);
        checks++; if (dout !== 8'h55) begin errors++; $display("FAIL overwrite1 got %h want 55", dout); end
    endtask

    task automatic test_non_pow2;
        cyc5(1'b1, 3'd4, 16'h1234);
        cyc5(1'b1, 3'd6, 16'hBEEF);
        cyc5(1'b0, 3'd4, 16'h0000);
        checks++; if (dout5 !== 16'h1234) begin errors++; $display("FAIL np2_read4a got %h want 1234", dout5); end
        cyc5(1'b0, 3'd6, 16'h0000);
        checks++; if (dout5 !== 16'h0000) begin errors++; $display("FAIL np2_read6 got %h want 0000", dout5); end
        cyc5(1'b1, 3'd7, 16'hDEAD);
        cyc5(1'b0, 3'd4, 16'h0000);
        checks++; if (dout5 !== 16'h1234) begin errors++; $display("FAIL np2_read4b got %h want 1234", dout5); end
        cyc5(1'b0, 3'd0, 16'h0000);
    endtask

    task automatic test_reset_preserves;
        cyc(1'b0, 1'b1, 7'd10, 8'h77);
        cyc(1'b1, 1'b0, 7'd10, 8'h00);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstp_during got %h want 00", dout); end
        cyc(1'b0, 1'b0, 7'd10, 8'h00);
        checks++; if (dout !== 8'h77) begin errors++; $display("FAIL rstp_read10 got %h want 77", dout); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 128; i++) cyc(1'b0, 1'b1, 7'(i), 8'($urandom));
        for (int i = 0; i < 128; i++) begin
            cyc(1'b0, 1'b0, 7'(i), 8'h00);
            checks++;
            if (dout !== exp_q) begin errors++; $display("FAIL b2b addr %0d got %h want %h", i, dout, exp_q); end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, 7'($urandom), 8'($urandom));
            checks++;
            if (dout !== exp_q) begin errors++; $display("FAIL random cycle %0d got %h want %h", i, dout, exp_q); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_m[i] = 'x;
        exp_q = 8'h00;
        test_reset;
        test_write_read;
        test_hold_on_write;
        test_overwrite;
        test_non_pow2;
        test_reset_preserves;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
